ts_sync_aligner: RTL

Byte-stream front end for the MPEG-2 TS QoS path. Hunts for the 0x47 sync byte at PKT_LEN-byte spacing, locks after LOCK_COUNT consecutive hits, and flywheels through up to UNLOCK_COUNT-1 consecutive misses. It drops lock on the UNLOCK_COUNT-th consecutive miss. Output is a byte stream with a valid/sync pair, where sync marks byte 0 of each packet. This stream feeds the continuity-counter packet-loss checker directly downstream.

---
 rtl/ts_sync_aligner.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner: MPEG-2 TS byte-stream sync aligner.
// It hunts for SYNC_BYTE at PKT_LEN spacing and locks after LOCK_COUNT consecutive hits.
// While locked it flywheels through up to UNLOCK_COUNT-1 consecutive boundary misses.
// Aligned bytes are forwarded with a one-cycle registered latency; out_sync marks packet byte 0.
// Optional build macro: TS_SYNC_INVERT_EN. When defined, ~SYNC_BYTE (DVB inverted sync) also counts as a match.
module ts_sync_aligner #(
    parameter int          PKT_LEN      = 188,
    parameter int          LOCK_COUNT   = 3,
    parameter int          UNLOCK_COUNT = 3,
    parameter logic [7:0]  SYNC_BYTE    = 8'h47
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic       out_sync,
    output logic [7:0] out_data,
    output logic       locked,
    output logic [7:0] sync_loss_count
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LAST_POS = 8'(PKT_LEN - 1);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    state_t     state_q, state_d;
    logic [7:0] pos_q, pos_d;
    logic [3:0] hit_q, hit_d;
    logic [3:0] miss_q, miss_d;
    logic [7:0] loss_q, loss_d;
    logic       out_valid_q, out_valid_d;
    logic       out_sync_q, out_sync_d;
    logic [7:0] out_data_q, out_data_d;

    logic       sync_match;
    logic       boundary;
    logic [7:0] pos_inc;
    logic [3:0] hit_inc;
    logic [3:0] miss_inc;

    // Classify the incoming byte and precompute the counter increments.
    always_comb begin
`ifdef TS_SYNC_INVERT_EN
        sync_match = (in_data == SYNC_BYTE) || (in_data == ~SYNC_BYTE);
`else
        sync_match = (in_data == SYNC_BYTE);
`endif
        boundary = (pos_q == 8'd0);
        pos_inc  = (pos_q == LAST_POS) ? 8'd0 : pos_q + 8'd1;
        hit_inc  = hit_q + 4'd1;
        miss_inc = miss_q + 4'd1;
    end

    // Next-state logic: hunt / verify / locked, plus the forwarded-byte register inputs.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        loss_d      = loss_q;
        out_valid_d = 1'b0;
        out_sync_d  = 1'b0;
        out_data_d  = out_data_q;

        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (sync_match) begin
                        hit_d = 4'd1;
                        pos_d = 8'd1;
                        if (LOCK_N == 4'd1) begin
                            // A single hit is enough: this byte is the locking byte.
                            state_d     = ST_LOCKED;
                            miss_d      = 4'd0;
                            out_valid_d = 1'b1;
                            out_sync_d  = 1'b1;
                            out_data_d  = in_data;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end
                end

                ST_VERIFY: begin
                    if (boundary && !sync_match) begin
                        // Candidate alignment failed; this byte is not reconsidered.
                        state_d = ST_HUNT;
                        hit_d   = 4'd0;
                        pos_d   = 8'd0;
                    end else begin
                        pos_d = pos_inc;
                        if (boundary) begin
                            hit_d = hit_inc;
                            if (hit_inc == LOCK_N) begin
                                state_d     = ST_LOCKED;
                                miss_d      = 4'd0;
                                out_valid_d = 1'b1;
                                out_sync_d  = 1'b1;
                                out_data_d  = in_data;
                            end
                        end
                    end
                end

                ST_LOCKED: begin
                    if (boundary && !sync_match && (miss_inc == UNLOCK_N)) begin
                        // Lock lost: the triggering byte is swallowed.
                        state_d = ST_HUNT;
                        hit_d   = 4'd0;
                        miss_d  = 4'd0;
                        pos_d   = 8'd0;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end else begin
                        pos_d       = pos_inc;
                        out_valid_d = 1'b1;
                        out_sync_d  = boundary;
                        out_data_d  = in_data;
                        if (boundary) begin
                            miss_d = sync_match ? 4'd0 : miss_inc;
                        end
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    hit_d   = 4'd0;
                    miss_d  = 4'd0;
                    pos_d   = 8'd0;
                end
            endcase
        end
    end

    // State and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            pos_q       <= 8'd0;
            hit_q       <= 4'd0;
            miss_q      <= 4'd0;
            loss_q      <= 8'd0;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
            out_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            loss_q      <= loss_d;
            out_valid_q <= out_valid_d;
            out_sync_q  <= out_sync_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_sync        = out_sync_q;
    assign out_data        = out_data_q;
    assign locked          = (state_q == ST_LOCKED);
    assign sync_loss_count = loss_q;

endmodule
